// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the dual-issue fetch path
package fetch_pkg;
  localparam int XLEN = 64;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;
  localparam logic [1:0] DEQ_NONE = 2'd0;
  localparam logic [1:0] DEQ_ONE  = 2'd1;
  localparam logic [1:0] DEQ_TWO  = 2'd2;
  function automatic logic [1:0] deq_clamp(input logic [1:0] d);
    return d[1] ? DEQ_TWO : (d[0] ? DEQ_ONE : DEQ_NONE);
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer, pair enqueue, up-to-two dequeue
module fetch_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_enq2,
  input  logic [XLEN-1:0] i_enq0_pc,
  input  logic [31:0]     i_enq0_instr,
  input  logic [XLEN-1:0] i_enq1_pc,
  input  logic [31:0]     i_enq1_instr,
  input  logic [1:0]      i_deq_cnt,
  output logic [CW-1:0]   o_count,
  output logic            o_out0_valid,
  output logic [31:0]     o_out0_instr,
  output logic [XLEN-1:0] o_out0_pc,
  output logic            o_out1_valid,
  output logic [31:0]     o_out1_instr,
  output logic [XLEN-1:0] o_out1_pc
);
  import fetch_pkg::*;
  logic [XLEN-1:0] r_pc_mem    [DEPTH];
  logic [31:0]     r_instr_mem [DEPTH];
  logic [PW-1:0]   r_rd, r_wr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   w_rd1, w_wr1;
  logic [1:0]      w_deq_req, w_deq_eff;
  assign w_rd1     = r_rd + PW'(1);
  assign w_wr1     = r_wr + PW'(1);
  assign w_deq_req = deq_clamp(i_deq_cnt);
  // over-requests shrink to what is actually held, so count never underflows
  assign w_deq_eff = (CW'(w_deq_req) > r_count) ? r_count[1:0] : w_deq_req;
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      r_rd    <= r_rd + PW'(w_deq_eff);
      r_wr    <= i_enq2 ? r_wr + PW'(2) : r_wr;
      r_count <= r_count - CW'(w_deq_eff) + (i_enq2 ? CW'(2) : CW'(0));
    end
  end
  always_ff @(posedge clk) begin
    if (i_enq2) begin
      r_pc_mem[r_wr]     <= i_enq0_pc;
      r_instr_mem[r_wr]  <= i_enq0_instr;
      r_pc_mem[w_wr1]    <= i_enq1_pc;
      r_instr_mem[w_wr1] <= i_enq1_instr;
    end
  end
  assign o_count      = r_count;
  assign o_out0_valid = r_count != '0;
  assign o_out1_valid = r_count > CW'(1);
  assign o_out0_instr = o_out0_valid ? r_instr_mem[r_rd] : '0;
  assign o_out0_pc    = o_out0_valid ? r_pc_mem[r_rd] : '0;
  assign o_out1_instr = o_out1_valid ? r_instr_mem[w_rd1] : '0;
  assign o_out1_pc    = o_out1_valid ? r_pc_mem[w_rd1] : '0;
endmodule

// File: rtl/fetch_ctrl_2way.sv
// fetch_ctrl_2way: dual-issue fetch PC, fetch gating and redirect handling
// feeding a two-wide instruction queue towards decode.
module fetch_ctrl_2way #(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc4,
  input  logic [31:0]     imem_instr1,
  input  logic [31:0]     imem_instr2,
  output logic            out0_valid,
  output logic            out1_valid,
  output logic [31:0]     out0_instr,
  output logic [31:0]     out1_instr,
  output logic [XLEN-1:0] out0_pc,
  output logic [XLEN-1:0] out1_pc,
  input  logic [1:0]      deq_cnt
);
  import fetch_pkg::*;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   w_count;
  logic            w_fetch;
  // free space judged before this cycle's dequeue, so a pair always fits
  assign w_fetch = fetch_en & ~stall & ~redirect_en & (w_count <= CW'(DEPTH - 2));
  assign pc      = r_pc;
  assign pc4     = r_pc + XLEN'(4);
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_pc <= RESET_PC;
    else if (redirect_en)
      r_pc <= redirect_pc & ~XLEN'(3);
    else if (w_fetch)
      r_pc <= r_pc + XLEN'(8);
  end
  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_flush      (redirect_en),
    .i_enq2       (w_fetch),
    .i_enq0_pc    (r_pc),
    .i_enq0_instr (imem_instr1),
    .i_enq1_pc    (pc4),
    .i_enq1_instr (imem_instr2),
    .i_deq_cnt    (deq_cnt),
    .o_count      (w_count),
    .o_out0_valid (out0_valid),
    .o_out0_instr (out0_instr),
    .o_out0_pc    (out0_pc),
    .o_out1_valid (out1_valid),
    .o_out1_instr (out1_instr),
    .o_out1_pc    (out1_pc)
  );
endmodule

// File: tb/tb_fetch_ctrl_2way.sv
// tb_fetch_ctrl_2way: directed plan scenarios plus random traffic vs a queue model
module tb_fetch_ctrl_2way;
  import fetch_pkg::*;
  localparam int          DEPTH    = 8;
  localparam logic [63:0] RESET_PC = 64'h0;
  logic        clk, rst_n, fetch_en, stall, redirect_en;
  logic [63:0] redirect_pc, pc, pc4, out0_pc, out1_pc;
  logic [31:0] imem_instr1, imem_instr2, out0_instr, out1_instr;
  logic        out0_valid, out1_valid;
  logic [1:0]  deq_cnt;
  int          n_chk, n_fail;
  fetch_entry_t mq[$];
  logic [63:0]  m_pc;

  fetch_ctrl_2way #(.XLEN(64), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .pc(pc), .pc4(pc4),
    .imem_instr1(imem_instr1), .imem_instr2(imem_instr2),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .out0_instr(out0_instr), .out1_instr(out1_instr),
    .out0_pc(out0_pc), .out1_pc(out1_pc), .deq_cnt(deq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h00:  return 32'h015A04B3;
      64'h04:  return 32'h00148493;
      64'h08:  return 32'hF0953823;
      64'h0C:  return 32'hF1053403;
      64'h54:  return 32'h014AEA13;
      64'h58:  return 32'h7FFAF993;
      default: return a[31:0] ^ a[63:32] ^ 32'hC0DE_0001;
    endcase
  endfunction

  assign imem_instr1 = imem(pc);
  assign imem_instr2 = imem(pc4);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    fetch_entry_t e0, e1;
    e0 = (mq.size() > 0) ? mq[0] : '0;
    e1 = (mq.size() > 1) ? mq[1] : '0;
    chk("pc", pc, m_pc);
    chk("pc4", pc4, m_pc + 64'd4);
    chk("out0_valid", 64'(out0_valid), 64'(mq.size() > 0));
    chk("out1_valid", 64'(out1_valid), 64'(mq.size() > 1));
    chk("out0_pc", out0_pc, e0.pc);
    chk("out0_instr", 64'(out0_instr), 64'(e0.instr));
    chk("out1_pc", out1_pc, e1.pc);
    chk("out1_instr", 64'(out1_instr), 64'(e1.instr));
  endtask

  task automatic model_update(input logic rn, fe, st, re, input logic [63:0] rp, input logic [1:0] dc);
    int free, d;
    free = DEPTH - mq.size();
    d = (dc == 2'd3) ? 2 : int'(dc);
    if (d > mq.size()) d = mq.size();
    if (!rn) begin
      mq.delete();
      m_pc = RESET_PC;
    end else if (re) begin
      mq.delete();
      m_pc = rp & ~64'd3;
    end else begin
      repeat (d) void'(mq.pop_front());
      if (fe && !st && free >= 2) begin
        mq.push_back('{pc: m_pc, instr: imem(m_pc)});
        mq.push_back('{pc: m_pc + 64'd4, instr: imem(m_pc + 64'd4)});
        m_pc = m_pc + 64'd8;
      end
    end
  endtask

  task automatic step(input logic rn, fe, st, re, input logic [63:0] rp, input logic [1:0] dc);
    @(negedge clk);
    rst_n = rn; fetch_en = fe; stall = st; redirect_en = re; redirect_pc = rp; deq_cnt = dc;
    #1;
    check_outputs();
    @(posedge clk);
    model_update(rn, fe, st, re, rp, dc);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 2'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    redirect_pc = '0; deq_cnt = '0;
    repeat (2) @(posedge clk);
    mq.delete();
    m_pc = RESET_PC;
    // streaming at full rate
    do_reset();
    step(1, 1, 0, 0, 0, 2'd2);
    #1;
    chk("stream_c1_pc0", out0_pc, 64'h00);
    chk("stream_c1_i0", 64'(out0_instr), 64'h015A04B3);
    chk("stream_c1_i1", 64'(out1_instr), 64'h00148493);
    repeat (4) step(1, 1, 0, 0, 0, 2'd2);
    // fill to full with no dequeue
    do_reset();
    repeat (6) step(1, 1, 0, 0, 0, 2'd0);
    #1;
    chk("full_pc_hold", pc, 64'h20);
    chk("full_head", 64'(out0_instr), 64'h015A04B3);
    // redirect with six entries held
    do_reset();
    repeat (3) step(1, 1, 0, 0, 0, 2'd0);
    step(1, 1, 0, 1, 64'h56, 2'd2);
    #1;
    chk("redir_pc", pc, 64'h54);
    chk("redir_v0", 64'(out0_valid), 64'h0);
    step(1, 1, 0, 0, 0, 2'd0);
    #1;
    chk("redir_i0", 64'(out0_instr), 64'h014AEA13);
    chk("redir_i1", 64'(out1_instr), 64'h7FFAF993);
    // stall while draining one per cycle
    repeat (3) step(1, 1, 1, 0, 0, 2'd1);
    repeat (3) step(1, 1, 0, 0, 0, 2'd1);
    // over-request with a single entry
    do_reset();
    step(1, 1, 0, 0, 0, 2'd0);
    step(1, 0, 0, 0, 0, 2'd1);
    step(1, 1, 0, 0, 0, 2'd2);
    step(1, 1, 0, 0, 0, 2'd3);
    step(1, 0, 0, 0, 0, 2'd3);
    // reset while full and fetching
    repeat (5) step(1, 1, 0, 0, 0, 2'd0);
    step(0, 1, 0, 0, 0, 2'd0);
    repeat (3) step(1, 1, 0, 0, 0, 2'd2);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] rp;
      rp = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           rp, 2'($urandom_range(0, 3)));
    end
    #1;
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl_2way.md
# fetch_ctrl_2way

Dual-issue fetch controller for the 2-way superscalar core. It owns the fetch PC and drives the pair of addresses (`pc`, `pc4`) into `instruction_mem`. It captures the returned instruction pair into a small circular instruction queue, and presents up to two ordered instructions per cycle to decode with a count-based dequeue handshake. Branch redirects flush the queue; stalls freeze fetch while decode keeps draining.

## Interface
Parameters:
- `XLEN`, 64, PC width
- `DEPTH`, 8, queue entries (single instructions); power of two, ≥4
- `RESET_PC`, 64'h0, fetch address after reset

Ports:
- `clk` in 1: rising-edge clock
- `rst_n` in 1: synchronous, active-low reset
- `fetch_en` in 1: fetch permitted when 1
- `stall` in 1: hold PC, no enqueue; dequeue unaffected
- `redirect_en` in 1: branch/jump redirect
- `redirect_pc` in XLEN: target; bits [1:0] ignored (forced 0)
- `pc` out XLEN: address to `instruction_mem` `PC`
- `pc4` out XLEN: address to `instruction_mem` `PC4`, always `pc + 4`
- `imem_instr1` in 32: instruction at `pc` (combinational from memory)
- `imem_instr2` in 32: instruction at `pc4`
- `out0_valid`, `out1_valid` out 1: oldest / second-oldest entry present
- `out0_instr`, `out1_instr` out 32: instruction words
- `out0_pc`, `out1_pc` out XLEN: PCs of those words
- `deq_cnt` in 2: instructions consumed this cycle (0, 1 or 2)

## Operation
- Fetch condition in cycle t is `fetch_en & ~stall & ~redirect_en & (free ≥ 2)`.
  - `free = DEPTH − count`, taken from the registered count before this cycle's dequeue.
- On fetch:
  - Enqueue `{pc, imem_instr1}`, then `{pc4, imem_instr2}`, in that order.
  - PC becomes `pc + 8`.
- No fetch: PC holds.
- Redirect:
  - Queue flushed (count to 0, pointers reset).
  - PC becomes `{redirect_pc[XLEN-1:2], 2'b00}`.
  - No enqueue and no dequeue that cycle.
- Dequeue:
  - The effective count is `min(deq_cnt, count)`.
  - `deq_cnt = 3` is treated as 2.
  - Over-requests are clamped and never underflow.
- Ordering:
  - `out0` is always the oldest entry.
  - `out1_valid` implies `out0_valid`.
- Same-cycle fetch and dequeue:
  - `count_next = count − deq_eff + 2`.
  - The count never exceeds `DEPTH` because the free check is conservative.
- Pointers wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits wide.
- PC arithmetic wraps modulo 2^XLEN.

## Timing
- Reset values (`rst_n=0` at a rising edge):
  - `pc = RESET_PC`, `pc4 = RESET_PC+4`
  - count 0
  - `out0_valid = out1_valid = 0`
  - `out*_instr = 0`, `out*_pc = 0` when invalid
- Reset mid-operation discards all queue contents at that edge.
- Fetch latency: a pair fetched at edge t appears on `out0`/`out1` after edge t, so it is usable in cycle t+1 when the queue was empty.
- Redirect asserted in cycle t:
  - `pc` equals the target in cycle t+1.
  - That pair is fetched in t+1 and visible in t+2.
- Throughput is 2 instructions/cycle sustained when `deq_cnt = 2` every cycle and `DEPTH ≥ 4`.
- `out*` are registered/queue-read outputs and have no combinational path from `deq_cnt`.
- Priority: `rst_n` > `redirect_en` > `stall` / `fetch_en`.

## Structure
- Package `fetch_pkg`:
  - `XLEN`
  - `fetch_entry_t` struct `{pc, instr}`
  - `DEQ_NONE / DEQ_ONE / DEQ_TWO` localparams
- Sub-module `fetch_queue`: circular buffer with two enqueue ports, two read ports, `enq2`, `deq_cnt`, `flush`, count.
- `fetch_ctrl_2way` holds the PC register, the fetch-condition logic and the redirect alignment.

## Test plan
Standard instruction image loaded (0x00 = 32'h015A04B3, 0x04 = 32'h00148493, 0x08 = 32'hF0953823, 0x0C = 32'hF1053403, 0x54 = 32'h014AEA13, 0x58 = 32'h7FFAF993).
- Reset, then `fetch_en=1`, `deq_cnt=2` each cycle:
  - cycle 1 shows `out0` = (0x00, 015A04B3) and `out1` = (0x04, 00148493).
  - cycle 2 shows 0x08/0x0C.
  - `pc` advances by 8 per cycle.
- `deq_cnt=0` with fetching:
  - count reaches 8 after 4 fetches.
  - `pc` then holds at 0x20.
  - no overwrite; `out0` still shows 0x00.
- `redirect_en=1`, `redirect_pc=0x56`, with the queue holding 6 entries:
  - next cycle, both valids are 0 and `pc=0x54`.
  - the cycle after, `out0` = (0x54, 014AEA13) and `out1` = (0x58, 7FFAF993).
- `stall=1` for 3 cycles with `deq_cnt=1`:
  - `pc` is frozen.
  - one entry drains per cycle, in order.
  - fetch resumes the cycle after `stall` drops.
- `deq_cnt=2` with only 1 entry valid:
  - count goes to 0 with no underflow.
  - the next pair is then enqueued correctly at the head.
- `rst_n=0` for one edge while full and fetching:
  - valids are 0 and `pc=RESET_PC`.
  - the sequence restarts at 0x00.
